// File: rtl/digital_stream_tx.sv
// Serial transmitter for the dCLK/dDAT/dFM telemetry link: pulls words from a
// first-word-fall-through FIFO and shifts them out MSB-first with a frame marker.
module digital_stream_tx #(
  parameter int                   CLK_DIV     = 4,
  parameter int                   WORD_BITS   = 12,
  parameter int                   FRAME_WORDS = 32,
  parameter logic [WORD_BITS-1:0] FILL_WORD   = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WORD_BITS-1:0] data,
  input  logic                 dataValid,
  output logic                 dataAccept,
  output logic                 dCLK,
  output logic                 dDAT,
  output logic                 dFM,
  output logic                 frameStart,
  output logic                 underrun
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int WORD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]    word_cnt_q, word_cnt_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic                 dclk_q, dclk_d;
  logic                 ddat_q, ddat_d;
  logic                 dfm_q, dfm_d;
  logic                 accept_q, accept_d;
  logic                 fs_q, fs_d;
  logic                 underrun_q, underrun_d;
  logic                 load;
  logic                 div_wrap;
  logic                 bit_last;
  logic [WORD_BITS-1:0] next_word;

  assign div_wrap  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign bit_last  = (bit_cnt_q == BIT_W'(WORD_BITS - 1));
  assign next_word = dataValid ? data : FILL_WORD;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    dclk_d     = dclk_q;
    ddat_d     = ddat_q;
    dfm_d      = dfm_q;
    accept_d   = 1'b0;
    fs_d       = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        dclk_d     = 1'b0;
        ddat_d     = 1'b0;
        dfm_d      = 1'b0;
        div_cnt_d  = '0;
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        if (enable) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT, DRAIN: begin
        state_d = enable ? SHIFT : DRAIN;
        if (div_wrap) begin
          div_cnt_d = '0;
          dclk_d    = ~dclk_q;
          if (dclk_q) begin
            if (bit_last) begin
              // word_cnt_q already points at the next word; 0 means the frame just ended
              if (!enable && word_cnt_q == '0) begin
                state_d   = IDLE;
                dclk_d    = 1'b0;
                ddat_d    = 1'b0;
                dfm_d     = 1'b0;
                bit_cnt_d = '0;
              end else begin
                load = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              shreg_d   = shreg_q << 1;
              ddat_d    = shreg_q[WORD_BITS-2];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      div_cnt_d  = '0;
      bit_cnt_d  = '0;
      shreg_d    = next_word;
      ddat_d     = next_word[WORD_BITS-1];
      accept_d   = dataValid;
      underrun_d = ~dataValid;
      fs_d       = (word_cnt_q == '0);
      dfm_d      = (word_cnt_q == '0);
      word_cnt_d = (word_cnt_q == WORD_W'(FRAME_WORDS - 1)) ? '0 : word_cnt_q + WORD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      dclk_q     <= 1'b0;
      ddat_q     <= 1'b0;
      dfm_q      <= 1'b0;
      accept_q   <= 1'b0;
      fs_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      dclk_q     <= dclk_d;
      ddat_q     <= ddat_d;
      dfm_q      <= dfm_d;
      accept_q   <= accept_d;
      fs_q       <= fs_d;
      underrun_q <= underrun_d;
    end
  end

  // The shift register is pure data: it is always reloaded before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign dCLK       = dclk_q;
  assign dDAT       = ddat_q;
  assign dFM        = dfm_q;
  assign dataAccept = accept_q;
  assign frameStart = fs_q;
  assign underrun   = underrun_q;

endmodule

// File: doc/digital_stream_tx.md
# digital_stream_tx

Serial transmitter for the three-wire digital telemetry link (dCLK, dDAT, dFM), i.e. the sending end of the stream that `digitalReceiver` decodes. It pulls fixed-width words from an upstream first-word-fall-through FIFO and shifts them out MSB-first. The link clock is derived from the system clock, and a frame marker is raised for the first word of every frame. It is used both as the bench-side source for the receive path and as the on-board digital output for loopback tests.

## Interface
- `CLK_DIV`, 4, system clocks per dCLK half period (≥2)
- `WORD_BITS`, 12, bits per word
- `FRAME_WORDS`, 32, words per frame (≥2)
- `FILL_WORD`, 12'h000, word sent when upstream has no data (width WORD_BITS)

- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `enable`  in  1  start/continue transmission
- `data`  in  WORD_BITS  upstream word (FWFT head)
- `dataValid`  in  1  `data` holds a valid word
- `dataAccept`  out  1  one-cycle pulse: word consumed, upstream pops
- `dCLK`  out  1  link clock
- `dDAT`  out  1  link data, MSB first
- `dFM`  out  1  frame marker
- `frameStart`  out  1  one-cycle pulse when word 0 of a frame is loaded
- `underrun`  out  1  one-cycle pulse when FILL_WORD is substituted

## Operation
- States: IDLE, SHIFT, DRAIN.
- Counters:
  - half-period `div_cnt` 0..CLK_DIV-1
  - `bit_cnt` 0..WORD_BITS-1
  - `word_cnt` 0..FRAME_WORDS-1
- **IDLE:** dCLK=0, dDAT=0, dFM=0, counters cleared.
  - If `enable`=1: load word 0 and go to SHIFT.
- **Word load cycle** (one clk cycle):
  - If `dataValid`=1: shift register ← `data`; `dataAccept`=1.
  - Else: shift register ← FILL_WORD; `underrun`=1.
  - `dataAccept` and `underrun` are never high in the same cycle.
  - `dataAccept` is never high while `dataValid`=0.
  - If `word_cnt`=0: `frameStart`=1 and dFM=1; otherwise dFM=0.
  - dDAT ← MSB of the loaded word.
- **SHIFT:**
  - When `div_cnt` wraps with dCLK=0, dCLK rises; the receiver samples here.
  - When `div_cnt` wraps with dCLK=1, dCLK falls and dDAT ← next bit.
  - After the falling edge of the last bit (bit_cnt=WORD_BITS-1), that same cycle is the next word load cycle. Words and frames are back-to-back, with no gap.
  - `word_cnt` wraps FRAME_WORDS-1 → 0.
- **`enable` deasserted mid-frame:** go to DRAIN.
  - The current frame completes normally, including loads and accepts for its remaining words.
  - At the falling edge ending the last bit of word FRAME_WORDS-1, drop dCLK/dDAT/dFM to 0 and go to IDLE. No load occurs at that edge.
  - `enable` reasserted during DRAIN returns to SHIFT with no interruption.
- **dFM:** held 1 for all bits of word 0, changing only on falling edges/load cycles.

## Timing
- All outputs registered.
- Reset values: dCLK=0, dDAT=0, dFM=0, `dataAccept`=0, `frameStart`=0, `underrun`=0; state IDLE.
- `reset`=0 at any time, including mid-word or mid-frame, forces reset values at the next edge. The partial word is discarded, with no accept.
- Start latency: `enable` sampled 1 at edge E0 in IDLE → load at E0.
  - dDAT=MSB visible after E0.
  - First dCLK rise after edge E0+CLK_DIV.
  - First fall after edge E0+2·CLK_DIV.
- Bit period: 2·CLK_DIV clk.
- Word period: WORD_BITS·2·CLK_DIV clk.
- Frame period: FRAME_WORDS times the word period.
- dDAT/dFM change only coincident with dCLK falling (or the initial load), giving CLK_DIV clk of setup and hold around each rising edge.
- `dataAccept`/`frameStart`/`underrun`: exactly one clk wide, aligned with the load cycle.

## Test plan
- CLK_DIV=2, WORD_BITS=12, FRAME_WORDS=4, FIFO preloaded with 12'hA5C, 12'h3F0, 12'h001, 12'hFFF, `enable`=1:
  - dDAT bits sampled on dCLK rises reproduce the four words MSB-first.
  - Rises occur every 4 clk.
  - dFM=1 for exactly the first 12 bits.
  - 4 `dataAccept` pulses, 1 `frameStart`.
- Empty FIFO, `enable`=1 for one frame:
  - 4 `underrun` pulses, 0 `dataAccept`.
  - dDAT all 0 (FILL_WORD).
  - dFM still marks word 0.
- Continuous stream over 3 frames:
  - No missing dCLK period between words or frames.
  - `frameStart` spacing is 4·12·4 = 192 clk.
- `enable` dropped during word 1:
  - Words 2 and 3 are still sent and accepted.
  - dCLK stays 0 after the final fall.
  - The FIFO word for the next frame remains unpopped.
- `reset`=0 during bit 5 of a word:
  - All outputs are 0 on the next edge.
  - After release with `enable`=1, the next word starts with dFM=1 and `frameStart`=1.
- `dataValid` toggling 1,0,1,0 across loads:
  - Alternating `dataAccept` and `underrun` pulses, never both in one cycle.
  - Sent words alternate between data and FILL_WORD accordingly.
